// File: rtl/fetch_unit_pkg.sv
// Constants shared by the fetch stage and its instruction queue.
package fetch_unit_pkg;
  localparam int          INST_WIDTH = 32;
  localparam int          PC_STEP    = 4;
  localparam logic [31:0] RV32_NOP   = 32'h0000_0013;
endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of {instruction, pc}; flush beats push/pop, power-of-two depth.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int                     DEPTH    = 2,
  parameter int                     AB       = 16,
  parameter logic [AB-1:0]          START_PC = '0,
  localparam int                    PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int                    CW       = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [INST_WIDTH-1:0] push_inst,
  input  logic [AB-1:0]         push_pc,
  input  logic                  pop,
  output logic                  valid,
  output logic [CW-1:0]         count,
  output logic [INST_WIDTH-1:0] head_inst,
  output logic [AB-1:0]         head_pc
);
  logic [INST_WIDTH-1:0] mem_inst [DEPTH];
  logic [AB-1:0]         mem_pc   [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [AB-1:0]         last_pc;

  assign valid     = (count != '0);
  assign head_inst = valid ? mem_inst[rd_ptr] : RV32_NOP;
  assign head_pc   = valid ? mem_pc[rd_ptr]   : last_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Remember the most recent head so an empty queue still reports a sane pc.
  always_ff @(posedge clock) begin
    if (reset)      last_pc <= START_PC;
    else if (valid) last_pc <= mem_pc[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem_inst[wr_ptr] <= push_inst;
      mem_pc[wr_ptr]   <= push_pc;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues 1-cycle imem reads, queues words for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                      ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] START_PC     = '0,
  parameter int                      QUEUE_DEPTH  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_pc,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0]   imem_rdata,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [INST_WIDTH-1:0]   instruction,
  output logic [ADDRESS_BITS-1:0] inst_pc
);
  localparam int CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int CW1 = CW + 1;

  logic [ADDRESS_BITS-1:0] fetch_pc, tag_pc;
  logic                    inflight, issue, push, pop, q_valid;
  logic [CW-1:0]           q_count;
  logic [CW1-1:0]          credit;

  assign inst_valid = q_valid && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign push       = inflight && !redirect_valid;

  // Slots already claimed after this cycle's pop; one in flight always has room.
  assign credit    = CW1'(q_count) + CW1'(inflight) - CW1'(pop);
  assign issue     = !reset && !redirect_valid && (credit < CW1'(QUEUE_DEPTH));
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= START_PC;
      inflight <= 1'b0;
      tag_pc   <= START_PC;
    end else begin
      inflight <= issue;
      if (redirect_valid)
        fetch_pc <= redirect_pc & ~ADDRESS_BITS'(3);
      else if (issue) begin
        fetch_pc <= fetch_pc + ADDRESS_BITS'(PC_STEP);
        tag_pc   <= fetch_pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH    (QUEUE_DEPTH),
    .AB       (ADDRESS_BITS),
    .START_PC (START_PC)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_inst (imem_rdata),
    .push_pc   (tag_pc),
    .pop       (pop),
    .valid     (q_valid),
    .count     (q_count),
    .head_inst (instruction),
    .head_pc   (inst_pc)
  );

  full_push_a: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && q_count == CW'(QUEUE_DEPTH)));
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference of the fetch stage.
module tb_fetch_unit;
  localparam int          AB    = 16;
  localparam int          DEPTH = 2;
  localparam logic [15:0] START = 16'h0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic [15:0] inst_pc;

  fetch_unit #(.ADDRESS_BITS(AB), .START_PC(START), .QUEUE_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: queue of pcs awaiting decode, one outstanding fetch, next pc.
  logic [15:0] mq[$];
  bit          m_infl;
  logic [15:0] m_infl_pc, m_npc, m_last;
  bit          rsp_pending;
  logic [15:0] rsp_addr;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit rv, input logic [15:0] rpc, input bit rdy);
    bit e_valid, e_req, pop;
    int credit;
    @(negedge clock);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    imem_rdata = rsp_pending ? mem_word(rsp_addr) : $urandom();
    #1;
    rsp_pending = (imem_req === 1'b1);
    rsp_addr    = imem_addr;
    if (rst) begin
      chk("req_in_reset", 32'(imem_req), 32'(0));
      mq.delete(); m_infl = 0; m_npc = START; m_last = START;
    end else begin
      e_valid = (mq.size() > 0) && !rv;
      pop     = e_valid && rdy;
      credit  = mq.size() + int'(m_infl) - int'(pop);
      e_req   = !rv && (credit < DEPTH);
      chk("inst_valid", 32'(inst_valid), 32'(e_valid));
      chk("imem_req",   32'(imem_req),   32'(e_req));
      chk("imem_addr",  32'(imem_addr),  32'(m_npc));
      if (mq.size() > 0) begin
        chk("inst_pc",     32'(inst_pc), 32'(mq[0]));
        chk("instruction", instruction,  mem_word(mq[0]));
        m_last = mq[0];
      end else begin
        chk("empty_nop", instruction,   NOP);
        chk("empty_pc",  32'(inst_pc),  32'(m_last));
      end
      if (rv) begin
        mq.delete();
        m_infl = 0;
        m_npc  = {rpc[15:2], 2'b00};
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_infl_pc);
        m_infl = e_req;
        if (e_req) begin
          m_infl_pc = m_npc;
          m_npc     = m_npc + 16'd4;
        end
      end
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, rdy);
  endtask

  initial begin
    rsp_pending = 0; rsp_addr = '0;
    m_infl = 0; m_infl_pc = '0; m_npc = START; m_last = START;
    // streaming from reset
    step(1, 0, 16'h0, 1); step(1, 0, 16'h0, 1);
    run(10, 1);
    // back-pressure fills the queue, then drains
    step(1, 0, 16'h0, 1);
    run(2, 1);
    run(5, 0);
    run(8, 1);
    // redirect with a full queue
    run(3, 0);
    step(0, 1, 16'h0102, 0);
    run(6, 1);
    // consecutive redirects, last one wins
    step(0, 1, 16'h0040, 1);
    step(0, 1, 16'h0080, 1);
    run(6, 1);
    // pc wraps at the top of the address space
    step(0, 1, 16'hFFF8, 1);
    run(6, 1);
    // single-cycle reset mid-stream
    run(3, 1);
    step(1, 0, 16'h0, 1);
    run(5, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 15) == 0),
           16'($urandom()),
           ($urandom_range(0, 3) != 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
